// File: rtl/lsq.sv
// lsq: in-order load/store queue between the execute stage and the data-memory bus.
// Define LSQ_MISALIGN_EXCP_EN to trap misaligned accesses instead of issuing them.
module lsq #(
  parameter int C_XLEN  = 32,
  parameter int C_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              clk_en_i,
  input  logic              exs_lq_wr_i,
  input  logic              exs_sq_wr_i,
  input  logic [2:0]        exs_funct3_i,
  input  logic [4:0]        exs_regd_addr_i,
  input  logic [C_XLEN-1:0] exs_regs2_data_i,
  input  logic [C_XLEN-1:0] exs_addr_i,
  output logic              exs_full_o,
  output logic              lsq_empty_o,
  output logic              dmem_req_o,
  input  logic              dmem_ack_i,
  output logic              dmem_we_o,
  output logic [C_XLEN-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [C_XLEN-1:0] dmem_wdata_o,
  input  logic              dmem_rvalid_i,
  input  logic [C_XLEN-1:0] dmem_rdata_i,
  output logic              regd_wr_o,
  input  logic              regd_ack_i,
  output logic [4:0]        regd_addr_o,
  output logic [C_XLEN-1:0] regd_data_o,
  output logic              hvec_lmaf_o,
  output logic              hvec_smaf_o
);

  localparam int PW = $clog2(C_DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(C_DEPTH);

  typedef enum logic [2:0] {IDLE, REQ, RESP, WB, FAULT} state_t;
  state_t state, state_nxt;

  logic [C_DEPTH-1:0] q_store;
  logic [2:0]         q_funct3 [C_DEPTH];
  logic [4:0]         q_regd   [C_DEPTH];
  logic [C_XLEN-1:0]  q_data   [C_DEPTH];
  logic [C_XLEN-1:0]  q_addr   [C_DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          push, pop;

  logic              h_store;
  logic [2:0]        h_funct3;
  logic [4:0]        h_regd;
  logic [C_XLEN-1:0] h_data;
  logic [C_XLEN-1:0] h_addr;
  logic [1:0]        h_a;

  logic [3:0]        lane_be;
  logic [C_XLEN-1:0] lane_wdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [C_XLEN-1:0] ld_ext;
  logic [C_XLEN-1:0] wb_data;
  logic [4:0]        wb_regd;

  assign h_store  = q_store[rd_ptr];
  assign h_funct3 = q_funct3[rd_ptr];
  assign h_regd   = q_regd[rd_ptr];
  assign h_data   = q_data[rd_ptr];
  assign h_addr   = q_addr[rd_ptr];
  assign h_a      = h_addr[1:0];

`ifdef LSQ_MISALIGN_EXCP_EN
  logic h_mis;
  always_comb begin
    h_mis = 1'b0;
    case (h_funct3[1:0])
      2'b00:   h_mis = 1'b0;
      2'b01:   h_mis = h_a[0];
      default: h_mis = (h_a != 2'b00);
    endcase
  end
`endif

  assign push = clk_en_i & (exs_lq_wr_i | exs_sq_wr_i) & ~exs_full_o;
  assign pop  = clk_en_i & (((state == REQ) & dmem_ack_i & h_store) |
                            ((state == WB) & regd_ack_i) |
                            (state == FAULT));

  // Entry storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_store[wr_ptr]  <= exs_sq_wr_i;
      q_funct3[wr_ptr] <= exs_funct3_i;
      q_regd[wr_ptr]   <= exs_regd_addr_i;
      q_data[wr_ptr]   <= exs_regs2_data_i;
      q_addr[wr_ptr]   <= exs_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) state <= IDLE;
    else if (clk_en_i) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (count != '0) begin
`ifdef LSQ_MISALIGN_EXCP_EN
          state_nxt = h_mis ? FAULT : REQ;
`else
          state_nxt = REQ;
`endif
        end
      end
      REQ:     if (dmem_ack_i) state_nxt = h_store ? IDLE : RESP;
      RESP:    if (dmem_rvalid_i) state_nxt = WB;
      WB:      if (regd_ack_i) state_nxt = IDLE;
      FAULT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Low address bits that cannot address a lane of the access size are ignored.
  always_comb begin
    case (h_funct3[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << h_a;
        lane_wdata = {4{h_data[7:0]}};
      end
      2'b01: begin
        lane_be    = h_a[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{h_data[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = h_data;
      end
    endcase
  end

  always_comb begin
    ld_byte = dmem_rdata_i[{h_a, 3'b000} +: 8];
    ld_half = h_a[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (h_funct3[1:0])
      2'b00:   ld_ext = {{(C_XLEN-8){~h_funct3[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{(C_XLEN-16){~h_funct3[2] & ld_half[15]}}, ld_half};
      default: ld_ext = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      wb_data <= '0;
      wb_regd <= '0;
    end else if (clk_en_i && state == RESP && dmem_rvalid_i) begin
      wb_data <= ld_ext;
      wb_regd <= h_regd;
    end
  end

  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_be_o    = '0;
    dmem_wdata_o = '0;
    regd_wr_o    = 1'b0;
    regd_addr_o  = '0;
    regd_data_o  = '0;
    hvec_lmaf_o  = 1'b0;
    hvec_smaf_o  = 1'b0;
    if (state == REQ) begin
      dmem_req_o   = 1'b1;
      dmem_we_o    = h_store;
      dmem_addr_o  = {h_addr[C_XLEN-1:2], 2'b00};
      dmem_be_o    = lane_be;
      dmem_wdata_o = lane_wdata;
    end
    if (state == WB) begin
      regd_wr_o   = 1'b1;
      regd_addr_o = wb_regd;
      regd_data_o = wb_data;
    end
`ifdef LSQ_MISALIGN_EXCP_EN
    if (state == FAULT) begin
      hvec_lmaf_o = ~h_store;
      hvec_smaf_o = h_store;
    end
`endif
    exs_full_o  = (count == CNT_FULL);
    lsq_empty_o = (count == '0) && (state == IDLE);
  end

  push_while_full: assert property (@(posedge clk_i) disable iff (!resetb_i)
    !(clk_en_i && (exs_lq_wr_i || exs_sq_wr_i) && exs_full_o))
    else $warning("lsq: push while full dropped");

endmodule

// File: tb/tb_lsq.sv
// tb_lsq: directed vectors, multi-cycle corner sequences and a randomized run against a queue model.
module tb_lsq;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetb, clk_en;
  logic        exs_lq_wr, exs_sq_wr;
  logic [2:0]  exs_funct3;
  logic [4:0]  exs_regd_addr;
  logic [31:0] exs_regs2_data, exs_addr;
  logic        exs_full_o, lsq_empty_o;
  logic        dmem_req_o, dmem_ack, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata;
  logic [3:0]  dmem_be_o;
  logic        dmem_rvalid;
  logic        regd_wr_o, regd_ack;
  logic [4:0]  regd_addr_o;
  logic [31:0] regd_data_o;
  logic        hvec_lmaf_o, hvec_smaf_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsq #(.C_XLEN(32), .C_DEPTH(DEPTH)) dut (
    .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en),
    .exs_lq_wr_i(exs_lq_wr), .exs_sq_wr_i(exs_sq_wr), .exs_funct3_i(exs_funct3),
    .exs_regd_addr_i(exs_regd_addr), .exs_regs2_data_i(exs_regs2_data), .exs_addr_i(exs_addr),
    .exs_full_o(exs_full_o), .lsq_empty_o(lsq_empty_o),
    .dmem_req_o(dmem_req_o), .dmem_ack_i(dmem_ack), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
    .regd_wr_o(regd_wr_o), .regd_ack_i(regd_ack), .regd_addr_o(regd_addr_o), .regd_data_o(regd_data_o),
    .hvec_lmaf_o(hvec_lmaf_o), .hvec_smaf_o(hvec_smaf_o)
  );

  always @(posedge clk) assert (!(exs_lq_wr && exs_sq_wr)) else $error("lq and sq write both high");

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Reference rules for lanes and load extension, expressed per byte.
  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int acc_off(input logic [31:0] addr, input logic [2:0] f3);
    int a = int'(addr % 4);
    return a - (a % acc_size(f3));
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] addr, input logic [2:0] f3);
    logic [3:0] be = '0;
    int o = acc_off(addr, f3);
    int s = acc_size(f3);
    for (int i = 0; i < 4; i++) if (i >= o && i < o + s) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [2:0] f3);
    logic [31:0] w;
    int s = acc_size(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % s) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] addr, input logic [2:0] f3);
    int s = acc_size(f3);
    int o = acc_off(addr, f3);
    logic [63:0] m = (64'd1 << (8*s)) - 64'd1;
    logic [63:0] v = ({32'd0, rd} >> (8*o)) & m;
    if (!f3[2] && s < 4 && v >= (m + 64'd1) / 2) v = v | ~m;
    return v[31:0];
  endfunction

  task automatic drive_push(input bit st, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] addr, input logic [31:0] data);
    exs_lq_wr = !st; exs_sq_wr = st; exs_funct3 = f3;
    exs_regd_addr = rd; exs_addr = addr; exs_regs2_data = data;
  endtask

  task automatic clear_push();
    exs_lq_wr = 1'b0; exs_sq_wr = 1'b0;
  endtask

  task automatic wait_req(input string name, input int budget);
    int n = 0;
    while (!dmem_req_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    chkb({name, "-req-timeout"}, dmem_req_o, 1'b1);
  endtask

  task automatic drain(input string nm, input logic [31:0] base, input int n, input bit chk_full);
    for (int k = 0; k < n; k++) begin
      wait_req(nm, 8);
      chk({nm, "-addr"}, dmem_addr_o, base + 32'(4*k));
      chk({nm, "-wdata"}, dmem_wdata_o, (base + 32'(4*k)) ^ 32'h5A5A_0000);
      dmem_ack = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0;
      if (chk_full && k == 0) chkb({nm, "-full-drop"}, exs_full_o, 1'b0);
    end
  endtask

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr, sdata, rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_val;
  } vec_t;
  vec_t vt[$];

  task automatic addv(input bit st, input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                      input logic [31:0] sdata, input logic [31:0] rdata, input logic [31:0] e_addr,
                      input logic [3:0] e_be, input logic [31:0] e_val);
    vec_t v;
    v.st = st; v.f3 = f3; v.rd = rd; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    v.e_addr = e_addr; v.e_be = e_be; v.e_val = e_val;
    vt.push_back(v);
  endtask

`ifdef LSQ_MISALIGN_EXCP_EN
  task automatic fault_seq(input string nm, input bit st, input logic [2:0] f3, input logic [31:0] addr);
    int pulses = 0;
    @(negedge clk);
    drive_push(st, f3, 5'd3, addr, 32'h0);
    @(negedge clk);
    clear_push();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chkb({nm, "-no-req"}, dmem_req_o, 1'b0);
      chkb({nm, "-no-wb"}, regd_wr_o, 1'b0);
      chkb({nm, "-other-vec"}, st ? hvec_lmaf_o : hvec_smaf_o, 1'b0);
      if (st ? hvec_smaf_o : hvec_lmaf_o) pulses++;
    end
    chk({nm, "-pulse-cycles"}, 32'(pulses), 32'd1);
    chkb({nm, "-empty"}, lsq_empty_o, 1'b1);
  endtask
`endif

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] sdata;
  } ent_t;

  initial begin
    vec_t v;
    ent_t q[$];
    bit resp_wait, wb_pend;
    logic [31:0] wb_exp;
    logic [4:0]  wb_rd;

    addv(1'b1, 3'b010, 5'd0,  32'h100, 32'hDEADBEEF, 32'h0,        32'h100, 4'b1111, 32'hDEADBEEF);
    addv(1'b0, 3'b000, 5'd5,  32'h103, 32'h0,        32'h80FFFFFF, 32'h100, 4'b1000, 32'hFFFFFF80);
    addv(1'b0, 3'b100, 5'd5,  32'h103, 32'h0,        32'h80FFFFFF, 32'h100, 4'b1000, 32'h00000080);
    addv(1'b1, 3'b001, 5'd0,  32'h102, 32'hFFFF1234, 32'h0,        32'h100, 4'b1100, 32'h12341234);
    addv(1'b0, 3'b001, 5'd12, 32'h202, 32'h0,        32'h80017FFF, 32'h200, 4'b1100, 32'hFFFF8001);
    addv(1'b0, 3'b101, 5'd31, 32'h200, 32'h0,        32'h80019ABC, 32'h200, 4'b0011, 32'h00009ABC);
    addv(1'b1, 3'b000, 5'd0,  32'h301, 32'h123456A5, 32'h0,        32'h300, 4'b0010, 32'hA5A5A5A5);
    addv(1'b0, 3'b010, 5'd1,  32'h400, 32'h0,        32'h12345678, 32'h400, 4'b1111, 32'h12345678);
    addv(1'b0, 3'b000, 5'd9,  32'h102, 32'h0,        32'h007F0000, 32'h100, 4'b0100, 32'h0000007F);
    addv(1'b1, 3'b011, 5'd0,  32'h500, 32'h01020304, 32'h0,        32'h500, 4'b1111, 32'h01020304);
`ifndef LSQ_MISALIGN_EXCP_EN
    addv(1'b0, 3'b010, 5'd7,  32'h101, 32'h0,        32'hCAFEF00D, 32'h100, 4'b1111, 32'hCAFEF00D);
    addv(1'b1, 3'b001, 5'd0,  32'h103, 32'h0000ABCD, 32'h0,        32'h100, 4'b1100, 32'hABCDABCD);
    addv(1'b0, 3'b001, 5'd4,  32'h101, 32'h0,        32'h11118765, 32'h100, 4'b0011, 32'hFFFF8765);
`endif

    resetb = 1'b0; clk_en = 1'b1;
    exs_lq_wr = 1'b0; exs_sq_wr = 1'b0; exs_funct3 = '0; exs_regd_addr = '0;
    exs_regs2_data = '0; exs_addr = '0;
    dmem_ack = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0; regd_ack = 1'b0;
    repeat (2) @(negedge clk);
    chkb("rst-empty", lsq_empty_o, 1'b1);
    chkb("rst-full", exs_full_o, 1'b0);
    chkb("rst-req", dmem_req_o, 1'b0);
    chkb("rst-wb", regd_wr_o, 1'b0);
    chk("rst-addr", dmem_addr_o, 32'h0);
    resetb = 1'b1;

    foreach (vt[i]) begin
      v = vt[i];
      @(negedge clk);
      drive_push(v.st, v.f3, v.rd, v.addr, v.sdata);
      @(negedge clk);
      clear_push();
      chkb("vec-req-early", dmem_req_o, 1'b0);
      @(negedge clk);
      chkb("vec-req-latency", dmem_req_o, 1'b1);
      chkb("vec-we", dmem_we_o, v.st);
      chk("vec-addr", dmem_addr_o, v.e_addr);
      chk("vec-be", 32'(dmem_be_o), 32'(v.e_be));
      if (v.st) chk("vec-wdata", dmem_wdata_o, v.e_val);
      dmem_ack = 1'b1;
      if (!v.st) begin
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hBAD0BAD0;
      end
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rvalid = 1'b0;
      chkb("vec-req-drop", dmem_req_o, 1'b0);
      if (v.st) chkb("vec-empty-store", lsq_empty_o, 1'b1);
      else begin
        chkb("vec-rvalid-with-ack-ignored", regd_wr_o, 1'b0);
        dmem_rvalid = 1'b1;
        dmem_rdata = v.rdata;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chkb("vec-wb", regd_wr_o, 1'b1);
        chk("vec-wb-addr", 32'(regd_addr_o), 32'(v.rd));
        chk("vec-wb-data", regd_data_o, v.e_val);
        regd_ack = 1'b1;
        @(negedge clk);
        regd_ack = 1'b0;
        chkb("vec-wb-drop", regd_wr_o, 1'b0);
        chkb("vec-empty-load", lsq_empty_o, 1'b1);
      end
    end

    // Fill with the bus stalled, then try one more push.
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      chkb("fill-not-full", exs_full_o, 1'b0);
      drive_push(1'b1, 3'b010, 5'd0, 32'h10 + 32'(4*k), (32'h10 + 32'(4*k)) ^ 32'h5A5A_0000);
    end
    @(negedge clk);
    chkb("fill-full", exs_full_o, 1'b1);
    drive_push(1'b1, 3'b010, 5'd0, 32'h20, 32'h20 ^ 32'h5A5A_0000);
    @(negedge clk);
    clear_push();
    chkb("fill-still-full", exs_full_o, 1'b1);
    drain("fill-drain", 32'h10, DEPTH, 1'b1);
    repeat (6) begin
      @(negedge clk);
      chkb("fill-no-fifth", dmem_req_o, 1'b0);
    end
    chkb("fill-empty", lsq_empty_o, 1'b1);

    // Push and pop in the same cycle at count 2.
    @(negedge clk);
    drive_push(1'b1, 3'b010, 5'd0, 32'h40, 32'h40 ^ 32'h5A5A_0000);
    @(negedge clk);
    drive_push(1'b1, 3'b010, 5'd0, 32'h44, 32'h44 ^ 32'h5A5A_0000);
    @(negedge clk);
    clear_push();
    wait_req("pp", 8);
    chk("pp-head", dmem_addr_o, 32'h40);
    dmem_ack = 1'b1;
    drive_push(1'b1, 3'b010, 5'd0, 32'h48, 32'h48 ^ 32'h5A5A_0000);
    @(negedge clk);
    dmem_ack = 1'b0;
    drive_push(1'b1, 3'b010, 5'd0, 32'h4C, 32'h4C ^ 32'h5A5A_0000);
    @(negedge clk);
    chkb("pp-count3", exs_full_o, 1'b0);
    drive_push(1'b1, 3'b010, 5'd0, 32'h50, 32'h50 ^ 32'h5A5A_0000);
    @(negedge clk);
    clear_push();
    chkb("pp-count4", exs_full_o, 1'b1);
    drain("pp-drain", 32'h44, DEPTH, 1'b0);
    @(negedge clk);
    chkb("pp-empty", lsq_empty_o, 1'b1);

    // Reset while a load waits for its response.
    @(negedge clk);
    drive_push(1'b0, 3'b010, 5'd9, 32'h60, 32'h0);
    @(negedge clk);
    clear_push();
    wait_req("rst-resp", 8);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    resetb = 1'b0;
    #2;
    chkb("rstm-req", dmem_req_o, 1'b0);
    chkb("rstm-wb", regd_wr_o, 1'b0);
    chkb("rstm-empty", lsq_empty_o, 1'b1);
    chkb("rstm-full", exs_full_o, 1'b0);
    @(negedge clk);
    resetb = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h77777777;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chkb("rstm-no-wb", regd_wr_o, 1'b0);
      chkb("rstm-no-req", dmem_req_o, 1'b0);
    end

`ifdef LSQ_MISALIGN_EXCP_EN
    fault_seq("lw-mis", 1'b0, 3'b010, 32'h101);
    fault_seq("sh-mis", 1'b1, 3'b001, 32'h103);
`endif

    // Randomized traffic against an in-order queue model.
    resp_wait = 1'b0; wb_pend = 1'b0; wb_exp = '0; wb_rd = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit en, do_push, acc_rv;
      ent_t e;
      @(negedge clk);
      chkb("r-full", exs_full_o, q.size() == DEPTH);
      chkb("r-empty", lsq_empty_o, q.size() == 0);
      chkb("r-req-legal", dmem_req_o && (q.size() == 0 || resp_wait || wb_pend), 1'b0);
      chkb("r-wb", regd_wr_o, wb_pend);
`ifndef LSQ_MISALIGN_EXCP_EN
      chkb("r-lmaf", hvec_lmaf_o, 1'b0);
      chkb("r-smaf", hvec_smaf_o, 1'b0);
`endif
      if (dmem_req_o && q.size() != 0) begin
        chkb("r-we", dmem_we_o, q[0].st);
        chk("r-addr", dmem_addr_o, q[0].addr & 32'hFFFF_FFFC);
        chk("r-be", 32'(dmem_be_o), 32'(ref_be(q[0].addr, q[0].f3)));
        if (q[0].st) chk("r-wdata", dmem_wdata_o, ref_wdata(q[0].sdata, q[0].f3));
      end
      if (regd_wr_o && wb_pend) begin
        chk("r-wb-addr", 32'(regd_addr_o), 32'(wb_rd));
        chk("r-wb-data", regd_data_o, wb_exp);
      end

      en = ($urandom_range(7) != 0);
      clk_en = en;
      dmem_ack = 1'($urandom_range(1));
      regd_ack = 1'($urandom_range(1));
      dmem_rvalid = 1'b0;
      if (resp_wait && $urandom_range(2) == 0) begin
        dmem_rvalid = 1'b1;
        dmem_rdata = $urandom;
      end
      acc_rv = dmem_rvalid;
      if (dmem_req_o && dmem_ack && q.size() != 0 && !q[0].st && $urandom_range(1) == 1) begin
        dmem_rvalid = 1'b1;
        dmem_rdata = $urandom;
      end
      do_push = (q.size() < DEPTH) && ($urandom_range(9) < 4);
      if (do_push) begin
        e.st = 1'($urandom_range(1));
        e.f3 = 3'($urandom_range(7));
        e.rd = 5'($urandom_range(31));
        e.sdata = $urandom;
        e.addr = $urandom;
`ifdef LSQ_MISALIGN_EXCP_EN
        if (e.f3[1:0] == 2'b01) e.addr[0] = 1'b0;
        else if (e.f3[1] == 1'b1) e.addr[1:0] = 2'b00;
`endif
        drive_push(e.st, e.f3, e.rd, e.addr, e.sdata);
      end else clear_push();

      if (en) begin
        if (acc_rv) begin
          wb_pend = 1'b1;
          resp_wait = 1'b0;
          wb_exp = ref_load(dmem_rdata, q[0].addr, q[0].f3);
          wb_rd = q[0].rd;
        end else if (wb_pend && regd_ack) begin
          wb_pend = 1'b0;
          void'(q.pop_front());
        end else if (dmem_req_o && dmem_ack && q.size() != 0) begin
          if (q[0].st) void'(q.pop_front());
          else resp_wait = 1'b1;
        end
        if (do_push) q.push_back(e);
      end
    end
    clear_push();
    clk_en = 1'b1; dmem_ack = 1'b0; dmem_rvalid = 1'b0; regd_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsq.md
Name: lsq

Overview:
- Load/store queue between the execute stage and the data-memory bus.
- Accepts load and store entries from the execute stage and holds them in a single in-order FIFO.
- Issues entries to memory one at a time, with exactly one transaction outstanding.
- Returns extended load data to the register-file write-back arbiter.
- Drives the full flag that the execute stage uses to stall.

Parameters:
- C_XLEN, 32, data/address width; only 32 is supported.
- C_DEPTH, 4, number of queue entries; must be a power of two, ≥2.

Ports:
- clk_i  in  1  clock
- resetb_i  in  1  reset, asynchronous, active-low
- clk_en_i  in  1  global clock enable; all state holds when low
- exs_lq_wr_i  in  1  push a load entry
- exs_sq_wr_i  in  1  push a store entry
- exs_funct3_i  in  3  access size/sign (RV32I LOAD/STORE funct3)
- exs_regd_addr_i  in  5  load destination register
- exs_regs2_data_i  in  C_XLEN  store data
- exs_addr_i  in  C_XLEN  byte address
- exs_full_o  out  1  queue full
- lsq_empty_o  out  1  queue empty and FSM idle
- dmem_req_o  out  1  bus request
- dmem_ack_i  in  1  request accepted
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  C_XLEN  word-aligned address ([1:0] = 0)
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  C_XLEN  lane-replicated store data
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  C_XLEN  read data
- regd_wr_o  out  1  load write-back request
- regd_ack_i  in  1  write-back accepted
- regd_addr_o  out  5  write-back register
- regd_data_o  out  C_XLEN  extended load data
- hvec_lmaf_o  out  1  load misaligned pulse
- hvec_smaf_o  out  1  store misaligned pulse

Behaviour:
- Reset: count=0, rd/wr pointers 0, FSM=IDLE. All outputs 0 except exs_full_o=0 and lsq_empty_o=1.
- All sequential updates are qualified by clk_en_i.

Queue:
- exs_full_o = (count==C_DEPTH), combinational from registered count.
- A push with exs_full_o=1 is ignored, and an assertion fires.
- exs_lq_wr_i and exs_sq_wr_i are never high together; the bench asserts this.
- Entry fields: {is_store, funct3, regd_addr, data, addr}.
- Pointers wrap modulo C_DEPTH.
- Push and pop in the same cycle leave count unchanged.

FSM (head entry only):
- IDLE → REQ when count≠0.
- REQ:
  - dmem_req_o=1; dmem_* outputs are driven from the head entry.
  - Outputs stay stable until the cycle in which dmem_ack_i=1.
  - Store: on ack, pop and go to IDLE.
  - Load: on ack, go to RESP.
- RESP:
  - Wait for dmem_rvalid_i.
  - On rvalid, capture the extended data into a register and go to WB.
  - rvalid in the same cycle as ack is not accepted; the earliest valid response is the cycle after ack.
- WB:
  - regd_wr_o=1 with registered addr/data.
  - On regd_ack_i, pop and go to IDLE.
- Load latency: push → dmem_req_o at +2 cycles with zero bus wait; regd_wr_o at the cycle after rvalid.

Byte lanes (a = addr[1:0]):
- funct3[1:0]=00 (byte): be = 0001<<a; wdata = byte replicated ×4.
- funct3[1:0]=01 (half): be = 0011<<(a[1]*2); wdata = half replicated ×2.
- funct3[1:0]=10 (word): be = 1111.
- funct3[1:0]=11 is reserved; treat it as word.

Load extension:
- Select the byte/half from rdata using a.
- Sign-extend when funct3[2]=0; zero-extend when funct3[2]=1.

Other:
- Reset mid-transaction aborts immediately; the bus slave is reset by the same resetb_i.
- lsq_empty_o = (count==0) & (state==IDLE).

Optional Feature:
- Macro: LSQ_MISALIGN_EXCP_EN.
- Defined:
  - A head entry is misaligned if it is a half with a[0]=1, or a word with a≠0.
  - A misaligned entry issues no bus request.
  - From IDLE it moves to a one-cycle FAULT state that pulses hvec_lmaf_o (load) or hvec_smaf_o (store), pops the entry, and returns to IDLE.
  - No register write-back occurs for a faulting load.
- Undefined:
  - hvec_lmaf_o and hvec_smaf_o are tied 0.
  - Offending low address bits are ignored: word uses a=0, half uses a[0]=0, then the access proceeds normally.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, ack same cycle → dmem_we_o=1, addr 0x100, be 1111, wdata 0xDEADBEEF; count returns to 0.
- LB x5, addr 0x103; rdata 0x80FF_FF_FF (byte3=0x80) → regd_data_o=0xFFFFFF80, regd_addr_o=5. Same access as LBU → 0x00000080.
- SH addr 0x102, data 0x1234 → be 1100, wdata 0x12341234.
- Hold dmem_ack_i=0, push C_DEPTH stores → exs_full_o=1 after the 4th push; a 5th push is ignored. Release ack → 4 in-order stores; full deasserts after the first pop.
- Push while popping at count 2 → count stays 2. Assert resetb_i=0 while in RESP → FSM IDLE, count 0, all outputs 0 next edge.
- With LSQ_MISALIGN_EXCP_EN: LW addr 0x101 → no dmem_req_o, hvec_lmaf_o one-cycle pulse, no regd_wr_o. Without it: request addr 0x100, be 1111.
